fc_frame_sequencer: RTL and testbench
=====================================

// Module: fc_frame_sequencer
// PURPOSE
//   Sequences one fully-connected neuron bank: accepts an input vector one element per beat,
//   holds it stable on x_out for the bank, and waits DP_LAT cycles for the datapath to settle.
//   It then snapshots all OUT neuron results and streams them out one per beat.
//   Sits between the upstream layer's output stream and the next layer's input stream.
// PARAMETERS
//   WIDTH   8    input element width (bits)
//   IN      128  elements per input vector
//   OUT     10   neurons in the bank (results per frame)
//   ZW      23   result width; 2*WIDTH+$clog2(IN)
//   DP_LAT  0    pipeline stages inside the neuron bank (0 = combinational)
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          synchronous reset, active-high
//   in_valid   in   1          input element valid
//   in_ready   out  1          sequencer can accept an element
//   in_data    in   WIDTH      input element
//   in_last    in   1          upstream marks final element of the vector
//   x_out      out  IN x WIDTH held input vector to the neuron bank
//   z_in       in   OUT x ZW   neuron bank results (ReLU already applied)
//   out_valid  out  1          result beat valid
//   out_ready  in   1          downstream accepts the result beat
//   out_data   out  ZW         result of neuron out_idx
//   out_last   out  1          beat carries neuron OUT-1
//   frame_done out  1          one-cycle pulse on the final output handshake
//   busy       out  1          high in WAIT or DRAIN
//   err        out  1          sticky in_last framing error
// BEHAVIOUR
//   Reset:
//   - state=LOAD; in_idx=0; out_idx=0.
//   - x_buf and res_buf cleared to 0.
//   - in_ready=1; out_valid=0; out_last=0; frame_done=0; busy=0; err=0.
//   - Reset mid-frame discards the partial vector and any undrained results.
//   Handshakes:
//   - A transfer occurs on valid&&ready at the rising edge.
//   - out_data and out_last stay stable while out_valid=1 and out_ready=0.
//   State LOAD:
//   - in_ready=1.
//   - Each in-handshake writes x_buf[in_idx] <= in_data and increments in_idx.
//   - On the handshake where in_idx==IN-1: in_idx<=0, wcnt<=DP_LAT, go to WAIT.
//   State WAIT:
//   - in_ready=0; busy=1.
//   - While wcnt!=0, decrement wcnt.
//   - When wcnt==0: res_buf[k] <= z_in[k] for all k, out_idx<=0, go to DRAIN.
//   - WAIT therefore lasts DP_LAT+1 cycles; the snapshot is taken no earlier than DP_LAT
//     cycles after the last x_buf write.
//   State DRAIN:
//   - out_valid=1; out_data=res_buf[out_idx]; out_last=(out_idx==OUT-1); in_ready=0; busy=1.
//   - Each out-handshake increments out_idx.
//   - Handshake with out_last=1: frame_done=1 for that one cycle, out_idx<=0, go to LOAD.
//   - The first element of the next frame is accepted one cycle after the final out-handshake.
//   Framing (the element count is authoritative):
//   - in_last=1 on any element other than index IN-1 sets err; the frame still completes at
//     IN elements.
//   - in_last=0 on element IN-1 also sets err.
//   - err clears only on rst.
//   Output stability:
//   - x_out is continuously driven from x_buf and is held until the next frame's writes.
//   - During LOAD, x_out is only partly updated; the bank output is valid only in WAIT.
//   Widths:
//   - Results are passed through unmodified; the sequencer performs no arithmetic on data.
//   - in_idx is $clog2(IN) bits; out_idx is $clog2(OUT) bits; neither index wraps outside its
//     state.
//   Throughput:
//   - IN + DP_LAT+1 + OUT cycles per frame with no backpressure.
//   - 139 cycles at the default parameters.
// TESTING
//   1. rst=1 for 2 cycles in mid-DRAIN -> next cycle state LOAD, out_valid=0, in_ready=1,
//      err=0, out_idx=0.
//   2. Stream x[i]=i+1 for i=0..127 with in_last on 127, out_ready=1, DP_LAT=0; golden-model
//      bank -> out_valid rises 1 cycle after beat 127, 10 beats equal the model,
//      out_last and frame_done on beat 9.
//   3. DP_LAT=3, bank modelled with a 3-stage delay -> snapshot taken 3 cycles after the last
//      write, busy=1 for 4 WAIT cycles, results match the model (no stale values).
//   4. out_ready toggles 1,0,0,1 during DRAIN -> out_data and out_last held during stalls;
//      exactly 10 handshakes; order idx 0..9.
//   5. in_valid toggled randomly at 50% -> x_buf matches only the accepted beats;
//      in_ready=0 through WAIT and DRAIN (beats offered there are not consumed).
//   6. in_last on element 63 -> err=1 from the next cycle; frame still drains 10 results after
//      128 elements; err stays 1 until rst.

Source files
------------

// File: rtl/fc_frame_sequencer.sv
// Frame sequencer for one fully-connected neuron bank:
// loads an input vector, waits for the bank to settle, then drains its results.
module fc_frame_sequencer #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int OUT    = 10,
  parameter int ZW     = 2*WIDTH+$clog2(IN),
  parameter int DP_LAT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_last,
  output logic [IN-1:0][WIDTH-1:0]  x_out,
  input  logic [OUT-1:0][ZW-1:0]    z_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ZW-1:0]             out_data,
  output logic                      out_last,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      err
);

  localparam int IW = (IN  > 1) ? $clog2(IN)  : 1;
  localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int WW = (DP_LAT > 0) ? $clog2(DP_LAT+1) : 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IW-1:0]             in_idx;
  logic [OW-1:0]             out_idx;
  logic [WW-1:0]             wcnt;
  logic [IN-1:0][WIDTH-1:0]  x_buf;
  logic [OUT-1:0][ZW-1:0]    res_buf;

  logic in_fire;
  logic out_fire;
  logic in_end;
  logic out_end;
  logic wait_end;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign in_end   = (in_idx == IW'(IN-1));
  assign out_end  = (out_idx == OW'(OUT-1));
  assign wait_end = (wcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (in_fire && in_end) state_nxt = WAIT;
      WAIT:    if (wait_end) state_nxt = DRAIN;
      DRAIN:   if (out_fire && out_end) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      LOAD:  in_ready = 1'b1;
      WAIT:  busy = 1'b1;
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign out_last   = out_valid && out_end;
  assign frame_done = out_fire && out_end;
  assign x_out      = x_buf;

  // explicit mux keeps unused out_idx codes from indexing past OUT-1
  always_comb begin
    out_data = '0;
    for (int k = 0; k < OUT; k++) begin
      if (out_idx == OW'(k)) out_data = res_buf[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx  <= '0;
      out_idx <= '0;
      wcnt    <= '0;
      x_buf   <= '0;
      res_buf <= '0;
      err     <= 1'b0;
    end else begin
      if (in_fire) begin
        x_buf[in_idx] <= in_data;
        in_idx        <= in_end ? '0 : in_idx + 1'b1;
        if (in_last != in_end) err <= 1'b1;
        if (in_end) wcnt <= WW'(DP_LAT);
      end
      if (state == WAIT) begin
        if (!wait_end) begin
          wcnt <= wcnt - 1'b1;
        end else begin
          res_buf <= z_in;
          out_idx <= '0;
        end
      end
      if (out_fire) begin
        out_idx <= out_end ? '0 : out_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_frame_sequencer.sv
// Bench for fc_frame_sequencer: two instances (DP_LAT=0 and DP_LAT=3)
// driven by directed frames with random data, checked against a vector model.
module tb_fc_frame_sequencer;

  localparam int WIDTH = 8;
  localparam int IN    = 128;
  localparam int OUT   = 10;
  localparam int ZW    = 23;

  typedef logic [IN-1:0][WIDTH-1:0] xv_t;
  typedef logic [OUT-1:0][ZW-1:0]   zv_t;

  logic clk = 1'b0;
  logic rst;
  logic iv, il, ordy, sel;
  logic [WIDTH-1:0] id;

  always #5 clk = ~clk;

  logic ir0, ov0, ol0, fd0, bz0, er0;
  logic ir3, ov3, ol3, fd3, bz3, er3;
  logic [ZW-1:0] od0, od3;
  xv_t x0, x3;
  zv_t z0, z3, p1, p2;

  function automatic int wt(input int k, input int i);
    return ((k*7 + i*3) % 13) + 1;
  endfunction

  function automatic zv_t bank(input xv_t x);
    zv_t r;
    for (int k = 0; k < OUT; k++) begin
      int s;
      s = 0;
      for (int i = 0; i < IN; i++) s += int'(x[i]) * wt(k, i);
      r[k] = ZW'(s);
    end
    return r;
  endfunction

  assign z0 = bank(x0);

  always_ff @(posedge clk) begin
    p1 <= bank(x3);
    p2 <= p1;
    z3 <= p2;
  end

  fc_frame_sequencer #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .ZW(ZW), .DP_LAT(0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(iv && !sel), .in_ready(ir0), .in_data(id), .in_last(il),
    .x_out(x0), .z_in(z0),
    .out_valid(ov0), .out_ready(ordy && !sel), .out_data(od0), .out_last(ol0),
    .frame_done(fd0), .busy(bz0), .err(er0)
  );

  fc_frame_sequencer #(.WIDTH(WIDTH), .IN(IN), .OUT(OUT), .ZW(ZW), .DP_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .in_valid(iv && sel), .in_ready(ir3), .in_data(id), .in_last(il),
    .x_out(x3), .z_in(z3),
    .out_valid(ov3), .out_ready(ordy && sel), .out_data(od3), .out_last(ol3),
    .frame_done(fd3), .busy(bz3), .err(er3)
  );

  logic ir, ov, ol, fd, bz, er;
  logic [ZW-1:0] od;
  xv_t xo;
  assign ir = sel ? ir3 : ir0;
  assign ov = sel ? ov3 : ov0;
  assign ol = sel ? ol3 : ol0;
  assign fd = sel ? fd3 : fd0;
  assign bz = sel ? bz3 : bz0;
  assign er = sel ? er3 : er0;
  assign od = sel ? od3 : od0;
  assign xo = sel ? x3 : x0;

  int checks = 0;
  int failures = 0;
  int xq[IN];
  int zexp[OUT];
  logic err_exp;
  int lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int mode, input int last_pos, input int prob);
    int cnt;
    int guard;
    cnt = 0;
    guard = 0;
    while (cnt < IN) begin
      @(negedge clk);
      iv = ($urandom_range(99) < prob);
      id = (mode == 0) ? WIDTH'(cnt + 1) : WIDTH'($urandom_range(255));
      il = (cnt == last_pos);
      #1;
      if (guard == 0) chk("ready_after_frame", 64'(ir), 64'd1);
      chk("in_ready_load", 64'(ir), 64'd1);
      chk("err_load", 64'(er), 64'(err_exp));
      if (iv && ir) begin
        xq[cnt] = int'(id);
        if ((cnt == last_pos) != (cnt == IN-1)) err_exp = 1'b1;
        cnt++;
      end
      guard++;
      if (guard > 2000) begin
        chk("send_timeout", 64'(cnt), 64'(IN));
        break;
      end
    end
    for (int k = 0; k < OUT; k++) begin
      zexp[k] = 0;
      for (int i = 0; i < IN; i++) zexp[k] += xq[i] * wt(k, i);
    end
  endtask

  task automatic drain(input int mode, input int stop);
    int idx;
    int wcyc;
    int vcyc;
    int guard;
    bit started;
    xv_t ex;
    idx = 0;
    wcyc = 0;
    vcyc = 0;
    guard = 0;
    started = 0;
    for (int i = 0; i < IN; i++) ex[i] = WIDTH'(xq[i]);
    while (idx < stop) begin
      @(negedge clk);
      iv = $urandom_range(1);
      id = WIDTH'($urandom_range(255));
      il = $urandom_range(1);
      if (mode == 0) ordy = 1'b1;
      else if (mode == 1) ordy = (vcyc % 4 == 0) || (vcyc % 4 == 3);
      else ordy = $urandom_range(1);
      #1;
      if (guard == 0) begin
        checks++;
        assert (xo === ex) else begin
          failures++;
          $error("FAIL x_out_hold observed=%0h expected=%0h", xo[3:0], ex[3:0]);
        end
      end
      chk("in_ready_busy", 64'(ir), 64'd0);
      chk("busy", 64'(bz), 64'd1);
      chk("err_busy", 64'(er), 64'(err_exp));
      if (!ov) begin
        chk("no_gap", 64'(started), 64'd0);
        wcyc++;
      end else begin
        if (!started) chk("wait_cycles", 64'(wcyc), 64'(lat + 1));
        started = 1;
        chk($sformatf("out_data[%0d]", idx), 64'(od), 64'(ZW'(zexp[idx])));
        chk("out_last", 64'(ol), 64'(idx == OUT-1));
        chk("frame_done", 64'(fd), 64'(ordy && idx == OUT-1));
        if (ordy) idx++;
        vcyc++;
      end
      guard++;
      if (guard > 500) begin
        chk("drain_timeout", 64'(idx), 64'(stop));
        break;
      end
    end
    @(negedge clk);
    iv = 1'b0;
    il = 1'b0;
    ordy = 1'b0;
  endtask

  initial begin
    sel = 1'b0;
    lat = 0;
    iv = 1'b0;
    il = 1'b0;
    id = '0;
    ordy = 1'b0;
    err_exp = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(ir), 64'd1);
    chk("rst_out_valid", 64'(ov), 64'd0);
    chk("rst_out_last", 64'(ol), 64'd0);
    chk("rst_frame_done", 64'(fd), 64'd0);
    chk("rst_busy", 64'(bz), 64'd0);
    chk("rst_err", 64'(er), 64'd0);
    rst = 1'b0;

    send_frame(0, IN-1, 100);
    drain(0, OUT);
    send_frame(1, IN-1, 100);
    drain(1, OUT);
    send_frame(1, IN-1, 50);
    drain(2, OUT);
    send_frame(1, 63, 100);
    drain(0, OUT);
    send_frame(1, IN-1, 100);
    drain(1, OUT);

    send_frame(1, IN-1, 100);
    drain(1, 4);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    err_exp = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(ir), 64'd1);
    chk("mid_rst_out_valid", 64'(ov), 64'd0);
    chk("mid_rst_busy", 64'(bz), 64'd0);
    chk("mid_rst_err", 64'(er), 64'd0);
    chk("mid_rst_out_idx", 64'(u0.out_idx), 64'd0);
    chk("mid_rst_in_idx", 64'(u0.in_idx), 64'd0);
    send_frame(1, -1, 100);
    drain(0, OUT);

    sel = 1'b1;
    lat = 3;
    err_exp = 1'b0;
    send_frame(1, IN-1, 100);
    drain(0, OUT);
    send_frame(1, IN-1, 100);
    drain(0, OUT);
    send_frame(1, IN-1, 50);
    drain(2, OUT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
